// File: rtl/decode_issue_queue_pkg.sv
// rtl/decode_issue_queue_pkg.sv - decoder types shared by the decode issue queue
package DecoderTypes;

    localparam int IQ_DEPTH_DEFAULT = 4;

    typedef logic [$clog2(IQ_DEPTH_DEFAULT):0] iq_occ_t;

    typedef enum logic [1:0] {
        IQ_EMPTY   = 2'd0,
        IQ_PARTIAL = 2'd1,
        IQ_FULL    = 2'd2
    } iq_state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_CMP  = 4'd7,
        OP_JMP  = 4'd8,
        OP_JCC  = 4'd9,
        OP_CALL = 4'd10,
        OP_RET  = 4'd11,
        OP_PUSH = 4'd12,
        OP_POP  = 4'd13,
        OP_LEA  = 4'd14,
        OP_BAD  = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        OPND_NONE = 2'd0,
        OPND_REG  = 2'd1,
        OPND_IMM  = 2'd2,
        OPND_MEM  = 2'd3
    } operand_kind_t;

    typedef struct packed {
        operand_kind_t kind;
        logic [31:0]   value;
    } operand_t;

    typedef struct packed {
        opcode_t     opcode;
        operand_t    operand0;
        operand_t    operand1;
        logic [63:0] pc;
        logic [3:0]  length;
    } fat_instruction_t;

    // Classifies an occupancy against a queue depth; the three states follow from
    // the occupancy arithmetic alone, so no separate state register exists.
    function automatic iq_state_t iq_state_of(input int unsigned occ, input int unsigned depth);
        if (occ == 0) begin
            return IQ_EMPTY;
        end else if (occ == depth) begin
            return IQ_FULL;
        end
        return IQ_PARTIAL;
    endfunction

endpackage

// File: rtl/decode_issue_queue_printer_pkg.sv
// rtl/decode_issue_queue_printer_pkg.sv - operand/instruction printer, compiled only with TRACE_PRINT_EN
`ifdef TRACE_PRINT_EN
package instr_printer_pkg;
    import DecoderTypes::*;

    function automatic string operand_to_string(input operand_t opnd);
        case (opnd.kind)
            OPND_REG: return $sformatf("r%0d", opnd.value);
            OPND_IMM: return $sformatf("0x%0h", opnd.value);
            OPND_MEM: return $sformatf("[0x%0h]", opnd.value);
            default:  return "-";
        endcase
    endfunction

    function automatic string instr_to_string(input fat_instruction_t instr);
        return $sformatf("%s %s, %s", instr.opcode.name(),
                         operand_to_string(instr.operand0),
                         operand_to_string(instr.operand1));
    endfunction

endpackage
`endif

// File: rtl/decode_issue_queue_wrap_ptr.sv
// rtl/decode_issue_queue_wrap_ptr.sv - wrapping pointer register with increment and synchronous clear
module iq_wrap_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // The queue depth is a power of two, so natural overflow wraps DEPTH-1 to 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/decode_issue_queue.sv
// rtl/decode_issue_queue.sv - in-order decode-to-execute issue queue; TRACE_PRINT_EN adds a dequeue trace
module decode_issue_queue
    import DecoderTypes::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  fat_instruction_t         enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output fat_instruction_t         deq_instr,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         issued_cnt
);

`ifdef TRACE_PRINT_EN
    import instr_printer_pkg::*;
`endif

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    fat_instruction_t   mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [OCC_W-1:0]   occ_q;
    logic [CNT_W-1:0]   cnt_q;
    iq_state_t          state;
    logic               enq_fire;
    logic               deq_fire;

    always_comb begin
        state = iq_state_of(int'(occ_q), DEPTH);
    end

    // No full-bypass: a full queue refuses enqueue even when the head leaves this cycle.
    assign enq_ready = (state != IQ_FULL) && !flush && !reset;
    assign deq_valid = (state != IQ_EMPTY) && !flush && !reset;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    assign deq_instr  = mem[head];
    assign occupancy  = occ_q;
    assign issued_cnt = cnt_q;

    iq_wrap_ptr #(.W(PTR_W)) u_head_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (deq_fire),
        .ptr   (head)
    );

    iq_wrap_ptr #(.W(PTR_W)) u_tail_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (enq_fire),
        .ptr   (tail)
    );

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail] <= enq_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else begin
            case ({enq_fire, deq_fire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // The issue count survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (deq_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef TRACE_PRINT_EN
    always_ff @(posedge clk) begin
        if (!reset && deq_fire) begin
            $display("%0d: %s", cnt_q, instr_to_string(deq_instr));
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_queue.sv
// tb/tb_decode_issue_queue.sv - scoreboard bench for decode_issue_queue
module tb_decode_issue_queue;
    import DecoderTypes::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CW    = 160;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic                 enq_valid;
    logic                 enq_ready;
    fat_instruction_t     enq_instr;
    logic                 deq_valid;
    logic                 deq_ready;
    fat_instruction_t     deq_instr;
    logic [2:0]           occupancy;
    logic [CNT_W-1:0]     issued_cnt;

    fat_instruction_t     sb[$];
    fat_instruction_t     exp_item;
    int                   n_checks;
    int                   n_fail;
    int                   total_deq;
    logic [CNT_W-1:0]     exp_cnt;
    logic [CNT_W-1:0]     saved_cnt;

    decode_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_instr  (enq_instr),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_instr  (deq_instr),
        .occupancy  (occupancy),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic fat_instruction_t mk(input int i);
        fat_instruction_t f;
        f.opcode         = opcode_t'(4'(i % 16));
        f.operand0.kind  = OPND_REG;
        f.operand0.value = 32'(i * 7 + 1);
        f.operand1.kind  = OPND_IMM;
        f.operand1.value = 32'(i * 13 + 5);
        f.pc             = 64'h1000 + 64'(i * 4);
        f.length         = 4'(i % 15 + 1);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted enqueues are pushed, observed dequeues popped and compared.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
            if (reset) begin
                exp_cnt   = '0;
                total_deq = 0;
            end
        end else begin
            if (deq_valid && deq_ready) begin
                if (sb.size() == 0) begin
                    check_eq("deq_unexpected", CW'(1), CW'(0));
                end else begin
                    exp_item = sb.pop_front();
                    check_eq("deq_instr", CW'(deq_instr), CW'(exp_item));
                end
                exp_cnt = exp_cnt + CNT_W'(1);
                total_deq++;
            end
            if (enq_valid && enq_ready) begin
                sb.push_back(enq_instr);
            end
        end
    end

    initial begin
        int id;
        int guard;
        n_checks  = 0;
        n_fail    = 0;
        total_deq = 0;
        exp_cnt   = '0;
        id        = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        enq_instr = mk(0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_enq_ready", CW'(enq_ready), CW'(1));
        check_eq("rst_deq_valid", CW'(deq_valid), CW'(0));
        check_eq("rst_occ", CW'(occupancy), CW'(0));
        check_eq("rst_cnt", CW'(issued_cnt), CW'(0));
        tick();

        // Fill to DEPTH with the consumer stalled, then try a fifth.
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_instr = mk(id);
            id++;
            tick();
        end
        enq_instr = mk(id);
        id++;
        @(negedge clk);
        check_eq("full_occ", CW'(occupancy), CW'(4));
        check_eq("full_enq_ready", CW'(enq_ready), CW'(0));
        tick();
        enq_valid = 1'b0;
        @(negedge clk);
        check_eq("full_occ_hold", CW'(occupancy), CW'(4));
        tick();
        deq_ready = 1'b1;
        repeat (4) tick();
        deq_ready = 1'b0;
        @(negedge clk);
        check_eq("drain_cnt", CW'(issued_cnt), CW'(4));
        check_eq("drain_occ", CW'(occupancy), CW'(0));
        check_eq("drain_sb", CW'(sb.size()), CW'(0));
        tick();

        // No pass-through when empty.
        enq_valid = 1'b1;
        enq_instr = mk(id);
        id++;
        deq_ready = 1'b1;
        @(negedge clk);
        check_eq("lat_deq_valid_n", CW'(deq_valid), CW'(0));
        tick();
        enq_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_deq_valid_n1", CW'(deq_valid), CW'(1));
        tick();
        deq_ready = 1'b0;

        // Occupancy 2 then streaming enq+deq across pointer wraps.
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1;
            enq_instr = mk(id);
            id++;
            tick();
        end
        saved_cnt = issued_cnt;
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_instr = mk(id);
            id++;
            @(negedge clk);
            check_eq("stream_occ", CW'(occupancy), CW'(2));
            tick();
        end
        @(negedge clk);
        check_eq("stream_occ_end", CW'(occupancy), CW'(2));
        check_eq("stream_cnt", CW'(issued_cnt), CW'(saved_cnt + CNT_W'(10)));
        check_eq("stream_cnt_model", CW'(issued_cnt), CW'(exp_cnt));

        // Bring occupancy to 3, then flush with the consumer ready.
        deq_ready = 1'b0;
        enq_instr = mk(id);
        id++;
        tick();
        enq_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_flush_occ", CW'(occupancy), CW'(3));
        saved_cnt = issued_cnt;
        tick();
        flush     = 1'b1;
        deq_ready = 1'b1;
        @(negedge clk);
        check_eq("flush_deq_valid", CW'(deq_valid), CW'(0));
        check_eq("flush_enq_ready", CW'(enq_ready), CW'(0));
        tick();
        flush     = 1'b0;
        enq_valid = 1'b1;
        enq_instr = mk(100);
        @(negedge clk);
        check_eq("post_flush_occ", CW'(occupancy), CW'(0));
        check_eq("post_flush_cnt", CW'(issued_cnt), CW'(saved_cnt));
        check_eq("post_flush_enq_ready", CW'(enq_ready), CW'(1));
        tick();
        enq_valid = 1'b0;
        @(negedge clk);
        check_eq("post_flush_head", CW'(deq_instr), CW'(mk(100)));
        tick();

        // Counter wrap: reset, then 16 dequeues bring a 4-bit count back to 0.
        reset     = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        tick();
        reset     = 1'b0;
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        guard     = 0;
        while (total_deq < 16 && guard < 200) begin
            enq_instr = mk(id);
            id++;
            if (total_deq == 15) enq_valid = 1'b0;
            tick();
            guard++;
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check_eq("wrap_timeout", CW'(guard < 200), CW'(1));
        @(negedge clk);
        check_eq("wrap_deqs", CW'(total_deq), CW'(16));
        check_eq("wrap_cnt", CW'(issued_cnt), CW'(0));
        tick();

        // Reset with two entries queued and both sides requesting.
        while (occupancy != 0) begin
            deq_ready = 1'b1;
            tick();
        end
        deq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1;
            enq_instr = mk(id);
            id++;
            tick();
        end
        @(negedge clk);
        check_eq("pre_rst_occ", CW'(occupancy), CW'(2));
        tick();
        reset     = 1'b1;
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_deq_valid", CW'(deq_valid), CW'(0));
        check_eq("rst_mid_enq_ready", CW'(enq_ready), CW'(0));
        tick();
        reset     = 1'b0;
        enq_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_occ", CW'(occupancy), CW'(0));
        check_eq("rst_mid_cnt", CW'(issued_cnt), CW'(0));
        check_eq("rst_mid_deq_valid_after", CW'(deq_valid), CW'(0));
        check_eq("final_sb", CW'(sb.size()), CW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
